// File: rtl/coincidence_trigger_handler.sv
// N-channel coincidence trigger: sync + edge detect, per-channel windows, OR/AND/majority fire, holdoff.
// Optional TRIGGER_TIMESTAMP_EN adds a free-running timestamp latched into TRIGGER_TIME on each trigger.
module coincidence_trigger_handler #(
    parameter int NCH    = 4,
    parameter int WIN_W  = 8,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16,
    parameter int THR_W  = 5
`ifdef TRIGGER_TIMESTAMP_EN
    ,
    parameter int TS_W   = 32
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH-1:0]    SIGNAL,
    input  logic              read_mode,
    input  logic [NCH-1:0]    CH_ENABLE,
    input  logic [1:0]        MODE,
    input  logic [THR_W-1:0]  THRESHOLD,
    input  logic [WIN_W-1:0]  WINDOW,
    input  logic [HOLD_W-1:0] HOLDOFF,
    input  logic              COUNT_CLEAR,
    output logic              TRIGGER_OUT,
    output logic [NCH-1:0]    TRIGGER_HITS,
    output logic [CNT_W-1:0]  TRIGGER_COUNT,
    output logic              BUSY
`ifdef TRIGGER_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]   TRIGGER_TIME
`endif
);

    typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

    state_t              state;
    logic [NCH-1:0]      s1, s2, s3;
    logic [NCH-1:0]      edges, armed, hit;
    logic [WIN_W-1:0]    timer [NCH];
    logic [HOLD_W-1:0]   hcnt;
    logic [THR_W-1:0]    pop;
    logic                mode_ok, fire;

    always_comb begin
        edges = s2 & ~s3 & CH_ENABLE;
        hit   = (edges | armed) & CH_ENABLE;
        pop   = '0;
        for (int unsigned i = 0; i < NCH; i++) pop = pop + THR_W'(hit[i]);
        case (MODE)
            2'b00:   mode_ok = |hit;
            2'b01:   mode_ok = (hit == CH_ENABLE) && (|CH_ENABLE);
            2'b10:   mode_ok = (pop >= THRESHOLD) && (|THRESHOLD);
            default: mode_ok = 1'b0;
        endcase
        // Only a fresh edge can fire; stale armed channels merely contribute.
        fire = (state == IDLE) && !read_mode && (|edges) && mode_ok;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= SIGNAL;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A zero window must not arm, so the hit lives only in the edge cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            armed <= '0;
            for (int unsigned i = 0; i < NCH; i++) timer[i] <= '0;
        end else if (state != IDLE || fire) begin
            armed <= '0;
            for (int unsigned i = 0; i < NCH; i++) timer[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (edges[i]) begin
                    armed[i] <= |WINDOW;
                    timer[i] <= WINDOW;
                end else if (armed[i]) begin
                    timer[i] <= timer[i] - WIN_W'(1);
                    if (timer[i] <= WIN_W'(1)) armed[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            hcnt          <= '0;
            TRIGGER_OUT   <= 1'b0;
            TRIGGER_HITS  <= '0;
            TRIGGER_COUNT <= '0;
            BUSY          <= 1'b0;
        end else begin
            TRIGGER_OUT <= 1'b0;
            if (state == FIRE)
                TRIGGER_COUNT <= COUNT_CLEAR ? CNT_W'(1)
                               : (&TRIGGER_COUNT) ? TRIGGER_COUNT
                               : TRIGGER_COUNT + CNT_W'(1);
            else if (COUNT_CLEAR)
                TRIGGER_COUNT <= '0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        state        <= FIRE;
                        TRIGGER_OUT  <= 1'b1;
                        TRIGGER_HITS <= hit;
                        BUSY         <= 1'b1;
                    end
                end
                FIRE: begin
                    if (HOLDOFF != '0) begin
                        state <= HOLD;
                        hcnt  <= HOLDOFF;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hcnt <= HOLD_W'(1)) begin
                        state <= IDLE;
                        hcnt  <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        hcnt <= hcnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRIGGER_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ts           <= '0;
            TRIGGER_TIME <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (fire) TRIGGER_TIME <= ts;
        end
    end
`endif

endmodule

// File: tb/tb_coincidence_trigger_handler.sv
// Randomized bench for coincidence_trigger_handler: cycle-level reference model feeds a trigger scoreboard.
module tb_coincidence_trigger_handler;
    localparam int NCH   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic [NCH-1:0]   SIGNAL = '0;
    logic             read_mode = 1'b0;
    logic [NCH-1:0]   CH_ENABLE = '0;
    logic [1:0]       MODE = 2'b11;
    logic [4:0]       THRESHOLD = '0;
    logic [7:0]       WINDOW = '0;
    logic [7:0]       HOLDOFF = '0;
    logic             COUNT_CLEAR = 1'b0;
    logic             TRIGGER_OUT;
    logic [NCH-1:0]   TRIGGER_HITS;
    logic [CNT_W-1:0] TRIGGER_COUNT;
    logic             BUSY;
`ifdef TRIGGER_TIMESTAMP_EN
    logic [31:0]      TRIGGER_TIME;
`endif

    coincidence_trigger_handler #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .SIGNAL(SIGNAL), .read_mode(read_mode),
        .CH_ENABLE(CH_ENABLE), .MODE(MODE), .THRESHOLD(THRESHOLD), .WINDOW(WINDOW),
        .HOLDOFF(HOLDOFF), .COUNT_CLEAR(COUNT_CLEAR), .TRIGGER_OUT(TRIGGER_OUT),
        .TRIGGER_HITS(TRIGGER_HITS), .TRIGGER_COUNT(TRIGGER_COUNT), .BUSY(BUSY)
`ifdef TRIGGER_TIMESTAMP_EN
        , .TRIGGER_TIME(TRIGGER_TIME)
`endif
    );

    always #5 CLK = ~CLK;

    // Inputs staged for the next cycle
    logic           nx_rst = 1'b0, nx_rm = 1'b0, nx_clr = 1'b0;
    logic [NCH-1:0] nx_sig = '0, nx_en = '0;
    logic [1:0]     nx_mode = 2'b11;
    logic [4:0]     nx_thr = '0;
    logic [7:0]     nx_win = '0, nx_hold = '0;

    int checks = 0, errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    // Reference model: sampled-input history, per-channel window deadlines, dead-time bounds
    logic [NCH-1:0] vcur = '0, vm1 = '0, vm2 = '0;
    int             dl [NCH];
    int             fire_cyc = -1, hold_end = -1, cnt_m = 0;
    logic [NCH-1:0] hits_m = '0;
    logic           exp_busy = 1'b0;
    int             exp_cnt = 0;
    logic [NCH-1:0] exp_hits = '0;

    typedef struct { int cyc; logic [NCH-1:0] hits; } trig_t;
    trig_t q [$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [NCH-1:0] e, h;
        int pc;
        logic ok, cond, busy;
        @(posedge CLK);
        #1;
        cyc++;
        vm2 = vm1;
        vm1 = vcur;
        vcur = RESET ? SIGNAL : '0;
        RESET = nx_rst; SIGNAL = nx_sig; read_mode = nx_rm; CH_ENABLE = nx_en;
        MODE = nx_mode; THRESHOLD = nx_thr; WINDOW = nx_win; HOLDOFF = nx_hold;
        COUNT_CLEAR = nx_clr;
        if (!RESET) begin
            vm1 = '0; vm2 = '0; vcur = '0;
            foreach (dl[i]) dl[i] = -1;
            fire_cyc = -1; hold_end = -1; cnt_m = 0; hits_m = '0;
            q.delete();
            exp_busy = 1'b0; exp_cnt = 0; exp_hits = '0;
        end else begin
            busy = (cyc == fire_cyc) || (cyc <= hold_end);
            if (cyc == fire_cyc) hold_end = cyc + int'(HOLDOFF);
            exp_busy = busy; exp_cnt = cnt_m; exp_hits = hits_m;
            e = vm1 & ~vm2 & CH_ENABLE;
            for (int i = 0; i < NCH; i++) h[i] = CH_ENABLE[i] & (e[i] | (cyc <= dl[i]));
            pc = $countones(h);
            case (MODE)
                2'd0:    ok = pc >= 1;
                2'd1:    ok = (h == CH_ENABLE) && (CH_ENABLE != '0);
                2'd2:    ok = (THRESHOLD != '0) && (pc >= int'(THRESHOLD));
                default: ok = 1'b0;
            endcase
            cond = !busy && !read_mode && (e != '0) && ok;
            if (cyc == fire_cyc) cnt_m = COUNT_CLEAR ? 1 : ((cnt_m == CMAX) ? CMAX : cnt_m + 1);
            else if (COUNT_CLEAR) cnt_m = 0;
            if (busy || cond) begin
                foreach (dl[i]) dl[i] = -1;
            end else begin
                for (int i = 0; i < NCH; i++) if (e[i]) dl[i] = cyc + int'(WINDOW);
            end
            if (cond) begin
                fire_cyc = cyc + 1;
                hits_m = h;
                q.push_back('{cyc + 1, h});
            end
        end
        started = 1'b1;
    endtask

`ifdef TRIGGER_TIMESTAMP_EN
    bit          have_prev = 1'b0;
    logic [31:0] prev_time;
    int          prev_cyc;
`endif

    // Monitor: per-cycle output checks plus trigger scoreboard
    always @(negedge CLK) begin
        if (started) begin
            logic exp_trig;
            trig_t t;
            chk("busy", 64'(BUSY), 64'(exp_busy));
            chk("count", 64'(TRIGGER_COUNT), 64'(exp_cnt));
            chk("hits_hold", 64'(TRIGGER_HITS), 64'(exp_hits));
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_trigger", 64'(0), 64'(1));
                void'(q.pop_front());
            end
            exp_trig = (q.size() > 0) && (q[0].cyc == cyc);
            chk("trigger_out", 64'(TRIGGER_OUT), 64'(exp_trig));
            if (exp_trig) begin
                t = q.pop_front();
                if (TRIGGER_OUT) begin
                    chk("trigger_hits", 64'(TRIGGER_HITS), 64'(t.hits));
`ifdef TRIGGER_TIMESTAMP_EN
                    if (have_prev)
                        chk("time_delta", 64'(TRIGGER_TIME - prev_time), 64'(32'(cyc - prev_cyc)));
                    have_prev = 1'b1; prev_time = TRIGGER_TIME; prev_cyc = cyc;
`endif
                end
            end
`ifdef TRIGGER_TIMESTAMP_EN
            if (!RESET) begin
                have_prev = 1'b0;
                chk("time_reset", 64'(TRIGGER_TIME), 64'(0));
            end
`endif
        end
    end

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic rise(input logic [NCH-1:0] m);
        nx_sig = nx_sig | m;
        step();
        nx_sig = nx_sig & ~m;
    endtask

    task automatic cfg(input logic [1:0] md, input logic [NCH-1:0] en, input logic [4:0] thr,
                       input logic [7:0] win, input logic [7:0] hold);
        nx_mode = md; nx_en = en; nx_thr = thr; nx_win = win; nx_hold = hold;
    endtask

    initial begin
        foreach (dl[i]) dl[i] = -1;
        nx_rst = 1'b0; idle(3);
        nx_rst = 1'b1; idle(2);

        // Single OR pulse on ch0
        cfg(2'd0, 4'b0001, 5'd0, 8'd0, 8'd0); idle(2);
        rise(4'b0001); idle(6);
        chk("first_count", 64'(TRIGGER_COUNT), 64'(1));

        // AND with window 4: gap 4 fires, gap 5 does not
        cfg(2'd1, 4'b0011, 5'd0, 8'd4, 8'd0); idle(2);
        rise(4'b0001); idle(3); rise(4'b0010); idle(8);
        rise(4'b0001); idle(4); rise(4'b0010); idle(8);

        // Majority of 3
        cfg(2'd2, 4'b1111, 5'd3, 8'd4, 8'd0); idle(2);
        rise(4'b0001); idle(1); rise(4'b0010); idle(1); rise(4'b0100); idle(8);
        rise(4'b0001); idle(1); rise(4'b0010); idle(8);
        nx_thr = 5'd0; rise(4'b0111); idle(8);

        // Holdoff 10 with edges every 5 cycles
        cfg(2'd0, 4'b0001, 5'd0, 8'd0, 8'd10); idle(2);
        repeat (3) begin rise(4'b0001); idle(4); end
        rise(4'b0001); idle(15);

        // Saturation, clear coincident with FIRE, reset mid-holdoff
        cfg(2'd0, 4'b0001, 5'd0, 8'd0, 8'd0); idle(2);
        repeat (18) begin rise(4'b0001); idle(3); end
        chk("saturated", 64'(TRIGGER_COUNT), 64'(CMAX));
        rise(4'b0001); idle(2);
        nx_clr = 1'b1; step(); nx_clr = 1'b0; idle(3);
        chk("clear_on_fire", 64'(TRIGGER_COUNT), 64'(1));
        nx_hold = 8'd20; rise(4'b0001); idle(8);
        nx_rst = 1'b0; idle(2); nx_rst = 1'b1; idle(2);
        chk("reset_busy", 64'(BUSY), 64'(0));
        rise(4'b0001); idle(6);

        // read_mode inhibits, then two triggers 100 cycles apart
        nx_hold = 8'd0; nx_rm = 1'b1; idle(1);
        rise(4'b0001); idle(6);
        chk("read_mode_count", 64'(TRIGGER_COUNT), 64'(1));
        nx_rm = 1'b0; idle(2);
        rise(4'b0001); idle(99); rise(4'b0001); idle(6);

        // Randomized configurations and sparse edges
        repeat (40) begin
            cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 5)),
                8'($urandom_range(0, 6)), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 8)));
            nx_rm = ($urandom_range(0, 4) == 0);
            repeat (60) begin
                for (int i = 0; i < NCH; i++)
                    if ($urandom_range(0, 5) == 0) nx_sig[i] = ~nx_sig[i];
                nx_clr = ($urandom_range(0, 39) == 0);
                step();
            end
        end
        nx_sig = '0; nx_clr = 1'b0; nx_rm = 1'b0; idle(20);
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coincidence_trigger_handler.md
Name: coincidence_trigger_handler

Overview:
- Parametrised N-channel successor to the two-channel edge trigger. Sits between SIGNAL_INPUT and readout, on the fast clock domain.
- Synchronises each discriminator line, detects rising edges and holds each edge open for a programmable coincidence window.
- Fires a one-cycle trigger in OR, AND or majority-of-N mode, then enforces a programmable holdoff (dead time).
- Reports the hit pattern that caused each trigger and keeps a saturating trigger count.

Parameters:
- NCH, 4, number of input channels (2..16).
- WIN_W, 8, width of WINDOW and per-channel window timers.
- HOLD_W, 8, width of HOLDOFF and holdoff counter.
- CNT_W, 16, width of TRIGGER_COUNT.
- THR_W, 5, width of THRESHOLD; must satisfy 2^THR_W > NCH.

Ports:
- CLK  in  1  fast clock.
- RESET  in  1  asynchronous reset, active-low.
- SIGNAL  in  NCH  asynchronous discriminator lines.
- read_mode  in  1  1 = readout in progress; new triggers inhibited.
- CH_ENABLE  in  NCH  per-channel participation mask.
- MODE  in  2  00 OR, 01 AND, 10 majority, 11 off.
- THRESHOLD  in  THR_W  majority threshold.
- WINDOW  in  WIN_W  coincidence window in cycles.
- HOLDOFF  in  HOLD_W  dead time after a trigger, in cycles.
- COUNT_CLEAR  in  1  synchronous clear of TRIGGER_COUNT.
- TRIGGER_OUT  out  1  one-cycle trigger pulse.
- TRIGGER_HITS  out  NCH  hit pattern latched at the trigger.
- TRIGGER_COUNT  out  CNT_W  saturating trigger counter.
- BUSY  out  1  high in FIRE and HOLDOFF.

Behaviour:
- Reset (RESET low, async): all outputs 0, synchronisers and timers 0, state IDLE.
- Input path per channel:
  - s1<=SIGNAL, s2<=s1, s3<=s2; edge = s2 & ~s3 & CH_ENABLE.
  - SIGNAL first sampled high at edge k gives edge true in the cycle after edge k+1.
- Window, per channel:
  - On edge: armed=1 and timer=WINDOW. A new edge re-arms and reloads.
  - Otherwise the timer decrements; armed clears when the timer reaches 0.
  - The channel stays armed for WINDOW cycles after its edge cycle. WINDOW=0 means the hit counts only in the edge cycle.
  - hit = (edge | armed) & CH_ENABLE.
- Condition: evaluated only in IDLE, with read_mode=0, and with any edge in the current cycle. Stale armed channels alone never fire.
  - OR: popcount(hit) >= 1.
  - AND: hit == CH_ENABLE and CH_ENABLE != 0.
  - MAJ: popcount(hit) >= THRESHOLD and THRESHOLD != 0.
  - Off: never.
- FSM:
  - IDLE: when the condition is met, go to FIRE.
  - FIRE (1 cycle):
    - TRIGGER_OUT=1 and BUSY=1.
    - TRIGGER_HITS <= hit from the condition cycle.
    - TRIGGER_COUNT increments, saturating at all-ones.
    - All armed flags clear.
    - Next state is HOLDOFF if HOLDOFF != 0, else IDLE.
  - HOLDOFF: counter loaded with HOLDOFF, runs for HOLDOFF cycles, then IDLE. Edges are ignored and not armed. BUSY=1.
- Latency: SIGNAL sampled high at edge k gives TRIGGER_OUT high in the cycle after edge k+2, which is 3 clocks.
- TRIGGER_HITS holds its value until the next FIRE.
- Config changes take effect immediately in IDLE. During HOLDOFF they do not alter the loaded counter.
- read_mode=1:
  - No FIRE.
  - Windows keep running.
  - A trigger already in progress completes.
- COUNT_CLEAR:
  - Clears TRIGGER_COUNT next cycle.
  - If it coincides with the FIRE increment, the result is 1.
- Reset asserted mid-HOLDOFF or mid-window returns to IDLE with everything cleared.

Optional Feature:
- Macro TRIGGER_TIMESTAMP_EN.
- Defined:
  - Adds parameter TS_W (default 32) and output TRIGGER_TIME [TS_W].
  - A free-running TS_W counter starts at 0 out of reset and wraps.
  - Its value is latched into TRIGGER_TIME in the FIRE cycle.
  - TRIGGER_TIME resets to 0.
- Undefined: no counter and no port; all other behaviour is identical.

Test Plan:
1. NCH=4, MODE=00, CH_ENABLE=0001, single SIGNAL[0] pulse -> TRIGGER_OUT high for exactly 1 cycle, 3 clocks after sampling; TRIGGER_HITS=0001, TRIGGER_COUNT=1.
2. MODE=01, CH_ENABLE=0011, WINDOW=4; ch0 edge at cycle t, ch1 edge at t+4 -> trigger with HITS=0011. Repeat with ch1 at t+5 -> no trigger.
3. MODE=10, THRESHOLD=3, CH_ENABLE=1111, WINDOW=4:
   - edges on ch0, ch1, ch2 within 4 cycles -> trigger with HITS=0111;
   - only ch0 and ch1 -> no trigger;
   - THRESHOLD=0 -> no trigger.
4. MODE=00, HOLDOFF=10, ch0 edge cycles e, e+5, e+10, e+15 -> triggers only from edges e and e+15; BUSY high from e+1 to e+11.
5. CNT_W=4: 16 triggers -> TRIGGER_COUNT stays at 15. COUNT_CLEAR in the same cycle as FIRE -> count 1. RESET low mid-HOLDOFF -> all outputs 0, next edge triggers normally.
6. read_mode=1 with a qualifying OR edge -> no TRIGGER_OUT and count unchanged. With TRIGGER_TIMESTAMP_EN, triggers 100 cycles apart -> TRIGGER_TIME difference = 100.
